// File: rtl/xvideoscan_if.sv
// Video scanner bus: memory read port on one side, VGA pins on the other.
interface xvideoscan_if #(
    parameter int unsigned COLS = 80,
    parameter int unsigned AW   = 5
);
    logic [AW-1:0]   addr_out;
    logic [COLS-1:0] data_in;
    logic            hsync;
    logic            vsync;
    logic            pixel;
    logic            video_on;
    logic            frame_start;

    // Scanner side drives the address and the display signals.
    modport master (
        output addr_out,
        output hsync,
        output vsync,
        output pixel,
        output video_on,
        output frame_start,
        input  data_in
    );

    // Memory / board side returns row data and observes the display signals.
    modport slave (
        input  addr_out,
        input  hsync,
        input  vsync,
        input  pixel,
        input  video_on,
        input  frame_start,
        output data_in
    );
endinterface

// File: rtl/xvideoscan.sv
// Read-side video scanner: VGA timing, one row fetch per cell row, 1-bit pixel serialiser.
module xvideoscan #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 27,
    parameter int unsigned CELL_W   = 8,
    parameter int unsigned CELL_H   = 16,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input logic          clk,
    input logic          rst_n,
    xvideoscan_if.master vid
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CIW      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned V_USED   = ROWS * CELL_H;
    localparam int unsigned CW_SH    = $clog2(CELL_W);
    localparam int unsigned CH_SH    = $clog2(CELL_H);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DW-1:0]   div_q, div_d;
    logic            tick;
    logic [HW-1:0]   hcount_q, hcount_d;
    logic [VW-1:0]   vcount_q, vcount_d;
    logic [VW-1:0]   next_v;
    logic            h_end, v_end;
    logic [AW-1:0]   addr_q, addr_d;
    logic [COLS-1:0] row_buf_q, row_buf_d;
    logic [CIW-1:0]  col_idx;
    logic            in_active, in_used;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            pixel_q, pixel_d;
    logic            video_on_q, video_on_d;
    logic            frame_start_q, frame_start_d;

    // Pixel-tick divider: tick on the last system clock of each pixel period.
    always_comb begin
        tick  = (div_q == DW'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Raster position counters, advanced once per tick.
    always_comb begin
        h_end    = (hcount_q == HW'(H_TOTAL - 1));
        v_end    = (vcount_q == VW'(V_TOTAL - 1));
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (h_end) begin
                hcount_d = '0;
                vcount_d = v_end ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    // Row fetch: address set at start of h-blank, data captured on the last pixel of the line.
    always_comb begin
        next_v    = v_end ? '0 : vcount_q + 1'b1;
        addr_d    = addr_q;
        row_buf_d = row_buf_q;
        if (tick && (hcount_q == HW'(H_ACTIVE))) begin
            // Lines below the used area park the address at row 0; pixels are blanked anyway.
            addr_d = (next_v < VW'(V_USED)) ? AW'(next_v >> CH_SH) : '0;
        end
        if (tick && h_end) begin
            row_buf_d = vid.data_in;
        end
    end

    // Output stage: decode the current position, registered on the tick.
    always_comb begin
        in_active = (hcount_q < HW'(H_ACTIVE)) && (vcount_q < VW'(V_ACTIVE));
        in_used   = (vcount_q < VW'(V_USED));
        col_idx   = '0;
        // Index only computed inside the active width so it never leaves 0..COLS-1.
        if (hcount_q < HW'(H_ACTIVE)) begin
            col_idx = CIW'(COLS - 1) - CIW'(hcount_q >> CW_SH);
        end
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        pixel_d       = pixel_q;
        video_on_d    = video_on_q;
        frame_start_d = tick && h_end && v_end;
        if (tick) begin
            video_on_d = in_active;
            pixel_d    = in_active && in_used && row_buf_q[col_idx];
            hsync_d    = !((hcount_q >= HW'(HS_START)) && (hcount_q < HW'(HS_END)));
            vsync_d    = !((vcount_q >= VW'(VS_START)) && (vcount_q < VW'(VS_END)));
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            addr_q        <= '0;
            row_buf_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            pixel_q       <= 1'b0;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            addr_q        <= addr_d;
            row_buf_q     <= row_buf_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pixel_q       <= pixel_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.addr_out    = addr_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.pixel       = pixel_q;
    assign vid.video_on    = video_on_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_xvideoscan.sv
// Bench: a scaled-down scanner checked every clock against a position-based model,
// plus a default-geometry scanner pinned on its first lines of VGA timing.
module tb_xvideoscan;
    // Scaled geometry so several whole frames fit in a short run.
    localparam int unsigned S_DIV   = 2;
    localparam int unsigned S_COLS  = 16;
    localparam int unsigned S_ROWS  = 5;
    localparam int unsigned S_CW    = 2;
    localparam int unsigned S_CH    = 2;
    localparam int unsigned S_HA    = 32;
    localparam int unsigned S_HFP   = 4;
    localparam int unsigned S_HS    = 6;
    localparam int unsigned S_HBP   = 6;
    localparam int unsigned S_VA    = 14;
    localparam int unsigned S_VFP   = 2;
    localparam int unsigned S_VS    = 2;
    localparam int unsigned S_VBP   = 3;
    localparam int unsigned S_HT    = 48;
    localparam int unsigned S_VT    = 21;
    localparam int unsigned S_USED  = 10;
    localparam int unsigned S_AW    = 3;
    localparam int unsigned S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ns;
    logic rst_nd;
    int   total = 0;
    int   bad   = 0;
    bit   d_done = 1'b0;

    xvideoscan_if #(.COLS(S_COLS), .AW(S_AW)) sif ();
    xvideoscan_if dif ();

    logic [S_COLS-1:0] mem_s [0:7];
    logic [79:0]       mem_d [0:31];

    assign sif.data_in = mem_s[sif.addr_out];
    assign dif.data_in = mem_d[dif.addr_out];

    xvideoscan #(
        .CLK_DIV(S_DIV), .COLS(S_COLS), .ROWS(S_ROWS), .CELL_W(S_CW), .CELL_H(S_CH),
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_ns),
        .vid   (sif)
    );

    xvideoscan dut_d (
        .clk   (clk),
        .rst_n (rst_nd),
        .vid   (dif)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // ---------------- model of the scaled scanner ----------------
    int          cyc = 0;
    logic [15:0] img;
    logic [2:0]  e_addr;
    logic        e_hs, e_vs, e_pix, e_von, e_fs;

    // Advance the model on each rising edge; position p is shown after tick p+1.
    initial begin
        int p, h, v, nv;
        logic [3:0] bi;
        logic [2:0] ri;
        img = '0; e_addr = '0; e_hs = 1'b1; e_vs = 1'b1; e_pix = 1'b0; e_von = 1'b0;
        e_fs = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_ns) begin
                cyc = 0; img = '0; e_addr = '0; e_hs = 1'b1; e_vs = 1'b1;
                e_pix = 1'b0; e_von = 1'b0; e_fs = 1'b0;
            end else begin
                cyc++;
                e_fs = 1'b0;
                if (cyc % S_DIV == 0) begin
                    p = cyc / S_DIV - 1;
                    h = p % S_HT;
                    v = (p / S_HT) % S_VT;
                    e_von = (h < S_HA) && (v < S_VA);
                    e_hs  = !((h >= S_HA + S_HFP) && (h < S_HA + S_HFP + S_HS));
                    e_vs  = !((v >= S_VA + S_VFP) && (v < S_VA + S_VFP + S_VS));
                    e_pix = 1'b0;
                    if (e_von && (v < S_USED)) begin
                        bi    = 4'(S_COLS - 1 - h / S_CW);
                        e_pix = img[bi];
                    end
                    e_fs = (h == S_HT - 1) && (v == S_VT - 1);
                    nv = (v + 1) % S_VT;
                    ri = (nv < S_USED) ? 3'(nv / S_CH) : 3'd0;
                    if (h == S_HA) e_addr = ri;
                    if (h == S_HT - 1) img = mem_s[ri];
                end
            end
        end
    end

    // Compare every falling edge: reset constants while in reset, model otherwise.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ns)
                check("scan_rst", 64'({sif.addr_out, sif.hsync, sif.vsync, sif.pixel,
                      sif.video_on, sif.frame_start}), 64'({3'd0, 5'b11000}));
            else
                check($sformatf("scan@%0d", cyc), 64'({sif.addr_out, sif.hsync, sif.vsync,
                      sif.pixel, sif.video_on, sif.frame_start}),
                      64'({e_addr, e_hs, e_vs, e_pix, e_von, e_fs}));
        end
    end

    function automatic int pos(input int f, input int v, input int h);
        return f * S_FRAME + v * S_HT + h;
    endfunction

    // Wait until position p has just been registered, then sit on the falling edge.
    task automatic goto(input int p);
        int tgt = (p + 1) * S_DIV;
        int g = 0;
        while (cyc != tgt && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != tgt) check("goto_timeout", 64'(cyc), 64'(tgt));
    endtask

    // ---------------- default-geometry instance: literal VGA timing ----------------
    initial begin
        int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1, von_rise = -1, von_fall = -1;
        logic phs = 1'b1, pvon = 1'b0, dfs = 1'b0, dvs_low = 1'b0, daddr_nz = 1'b0;
        for (int r = 0; r < 32; r++) mem_d[r] = '0;
        mem_d[0] = {1'b1, 78'd0, 1'b1};
        wait (rst_nd === 1'b1);
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk);
            if (phs && !dif.hsync) begin
                if (hs_fall1 < 0) hs_fall1 = n;
                else if (hs_fall2 < 0) hs_fall2 = n;
            end
            if (!phs && dif.hsync && hs_rise1 < 0) hs_rise1 = n;
            if (!pvon && dif.video_on && von_rise < 0) von_rise = n;
            if (pvon && !dif.video_on && von_fall < 0) von_fall = n;
            if (dif.frame_start) dfs = 1'b1;
            if (!dif.vsync) dvs_low = 1'b1;
            if (dif.addr_out != 5'd0) daddr_nz = 1'b1;
            phs  = dif.hsync;
            pvon = dif.video_on;
        end
        check("d_hs_first_fall", 64'(hs_fall1), 64'd2628);
        check("d_hs_period", 64'(hs_fall2 - hs_fall1), 64'd3200);
        check("d_hs_low", 64'(hs_rise1 - hs_fall1), 64'd384);
        check("d_von_rise", 64'(von_rise), 64'd4);
        check("d_von_high", 64'(von_fall - von_rise), 64'd2560);
        check_bit("d_no_frame_start", dfs, 1'b0);
        check_bit("d_no_vsync", dvs_low, 1'b0);
        check_bit("d_addr_row0", daddr_nz, 1'b0);
        d_done = 1'b1;
    end

    // ---------------- directed sequence on the scaled instance ----------------
    initial begin
        int g;
        rst_ns = 1'b0;
        rst_nd = 1'b0;
        for (int r = 0; r < 8; r++) mem_s[r] = '0;
        mem_s[0] = 16'h8001;
        mem_s[1] = 16'hA5C3;
        mem_s[2] = 16'h0FF0;
        mem_s[3] = 16'h0000;
        mem_s[4] = 16'hFFFF;
        repeat (3) @(negedge clk);
        check_bit("rst_hsync", sif.hsync, 1'b1);
        check_bit("rst_vsync", sif.vsync, 1'b1);
        check_bit("rst_video_on", sif.video_on, 1'b0);
        check_bit("d_rst_hsync", dif.hsync, 1'b1);
        rst_ns = 1'b1;
        rst_nd = 1'b1;

        goto(pos(0, 0, 0));
        check_bit("first_tick_fs", sif.frame_start, 1'b0);
        check_bit("first_video_on", sif.video_on, 1'b1);
        check_bit("line0_blank", sif.pixel, 1'b0);
        goto(pos(0, 1, 0));  check_bit("l1_h0", sif.pixel, 1'b1);
        goto(pos(0, 1, 1));  check_bit("l1_h1", sif.pixel, 1'b1);
        goto(pos(0, 1, 2));  check_bit("l1_h2", sif.pixel, 1'b0);
        goto(pos(0, 1, 29)); check_bit("l1_h29", sif.pixel, 1'b0);
        goto(pos(0, 1, 30)); check_bit("l1_h30", sif.pixel, 1'b1);
        goto(pos(0, 5, 0));  check_bit("row2_dark_edge", sif.pixel, 1'b0);
        goto(pos(0, 6, 10)); check_bit("row3_dark", sif.pixel, 1'b0);
        goto(pos(0, 7, 31)); check("addr_before", 64'(sif.addr_out), 64'd3);
        goto(pos(0, 7, 32)); check("addr_after", 64'(sif.addr_out), 64'd4);
        goto(pos(0, 7, 35)); check_bit("hs_before", sif.hsync, 1'b1);
        goto(pos(0, 7, 36)); check_bit("hs_start", sif.hsync, 1'b0);
        goto(pos(0, 7, 41)); check_bit("hs_last", sif.hsync, 1'b0);
        goto(pos(0, 7, 42)); check_bit("hs_end", sif.hsync, 1'b1);
        goto(pos(0, 8, 5));  check_bit("row4_lit", sif.pixel, 1'b1);
        goto(pos(0, 9, 32));
        check("addr_wrap0", 64'(sif.addr_out), 64'd0);
        check_bit("hblank_off", sif.video_on, 1'b0);
        goto(pos(0, 10, 0));
        check_bit("below_used_dark", sif.pixel, 1'b0);
        check_bit("below_used_on", sif.video_on, 1'b1);
        goto(pos(0, 16, 0)); check_bit("vs_start", sif.vsync, 1'b0);
        goto(pos(0, 18, 0)); check_bit("vs_end", sif.vsync, 1'b1);
        goto(pos(0, 20, 47)); check_bit("frame_start", sif.frame_start, 1'b1);
        goto(pos(1, 0, 0));
        check_bit("f2_line0_row0", sif.pixel, 1'b1);
        check_bit("fs_one_clk", sif.frame_start, 1'b0);

        // Row 3 rewritten after line 6 has been captured.
        goto(pos(1, 6, 10));
        mem_s[3] = 16'hFFFF;
        goto(pos(1, 6, 20)); check_bit("old_row_kept", sif.pixel, 1'b0);
        goto(pos(1, 7, 20)); check_bit("new_row_shown", sif.pixel, 1'b1);

        // Mid-line reset.
        goto(pos(1, 8, 20));
        check_bit("pre_rst_pixel", sif.pixel, 1'b1);
        @(posedge clk);
        #1 rst_ns = 1'b0;
        #1;
        check_bit("async_rst_pixel", sif.pixel, 1'b0);
        check_bit("async_rst_von", sif.video_on, 1'b0);
        check("async_rst_addr", 64'(sif.addr_out), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ns = 1'b1;

        goto(pos(0, 0, 0));
        check_bit("rerun_fs", sif.frame_start, 1'b0);
        check_bit("rerun_line0_blank", sif.pixel, 1'b0);
        goto(pos(0, 1, 0));  check_bit("rerun_l1_h0", sif.pixel, 1'b1);
        goto(pos(0, 7, 36)); check_bit("rerun_hs", sif.hsync, 1'b0);
        goto(pos(0, 20, 47)); check_bit("rerun_frame_start", sif.frame_start, 1'b1);
        goto(pos(1, 0, 5));

        g = 0;
        while (!d_done && g < 10000) begin
            @(negedge clk);
            g++;
        end
        check_bit("d_done", d_done, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
